serial_add_sub: RTL and testbench
=================================

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request pulse; sampled on rising edge.
REQ-005 M  input  1  mode: 0 = A+B, 1 = A-B; sampled with start.
REQ-006 A  input  WIDTH  first operand; sampled with start.
REQ-007 B  input  WIDTH  second operand; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking valid result.
REQ-010 S  output  WIDTH  result, sum or difference modulo 2^WIDTH.
REQ-011 Cout  output  1  final carry; in subtract mode 1 = no borrow (A >= B unsigned).
REQ-012 V  output  1  two's-complement signed overflow of the last operation.

Function
REQ-013 Datapath: one 1-bit full adder/subtractor slice (B bit XOR M into full adder), reused once per cycle, LSB first.
REQ-014 FSM states: IDLE, RUN, DONE; encoding free.
REQ-015 IDLE or DONE with start=1: latch A, B, M into operand shift registers; carry flop <= M; bit counter <= 0; next state RUN.
REQ-016 IDLE with start=0: hold state; DONE with start=0: next state IDLE.
REQ-017 RUN, each edge: compute bit i from operand LSBs and carry flop; update carry; shift operand registers right by 1; shift sum bit into MSB of internal result register; counter increments.
REQ-018 RUN exits to DONE on the edge processing bit WIDTH-1, i.e. exactly WIDTH edges in RUN.
REQ-019 Latency: start sampled at edge E0; done high in the cycle following edge E(WIDTH), low after E(WIDTH+1) unless a new operation completes.
REQ-020 busy = 1 exactly while in RUN; done = 1 exactly while in DONE; never both high.
REQ-021 start while in RUN: ignored; no restart, no effect on result.
REQ-022 A, B, M changes after the sampling edge: no effect on the running operation.
REQ-023 S, Cout, V: registered; updated only on the edge entering DONE; held stable otherwise, including throughout a subsequent RUN.
REQ-024 Cout = carry out of bit WIDTH-1; V = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-025 Results are bit-exact with WIDTH-bit A + (B XOR {WIDTH{M}}) + M.

Reset
REQ-026 rst_n=0 at a rising edge: state <= IDLE; busy=0, done=0, S=0, Cout=0, V=0; operand registers, carry flop, and counter cleared.
REQ-027 Reset takes priority over start and over any in-progress operation; an aborted operation produces no done pulse.
REQ-028 With rst_n=0, no output changes except at a clock edge (synchronous only).

Verification (WIDTH=8)
REQ-029 M=0, A=8'h25, B=8'h1A, start at E0 -> busy high for 8 cycles; done in the cycle after E8; S=8'h3F, Cout=0, V=0.
REQ-030 M=0, A=8'hFF, B=8'h01 -> S=8'h00, Cout=1, V=0; M=0, A=8'h7F, B=8'h01 -> S=8'h80, Cout=0, V=1.
REQ-031 M=1, A=8'h05, B=8'h07 -> S=8'hFE, Cout=0, V=0; M=1, A=8'h80, B=8'h01 -> S=8'h7F, Cout=1, V=1.
REQ-032 Reset mid-operation:
- Start an operation, then assert rst_n=0 at E3 -> after E3, busy=0, done=0, S=8'h00, and no done pulse follows.
- Start a new operation -> completes normally.
REQ-033 Operand and start stability:
- Start with A=8'h10, B=8'h20, M=0.
- During RUN, toggle start and change A, B, and M.
- Required: a single done with S=8'h30, and busy stays continuous.
REQ-034 Back-to-back: start held high in the DONE cycle -> the new operation is accepted immediately, busy rises the next cycle, and the prior S holds until the new done.

Source files
------------

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice reused LSB first,
// WIDTH cycles per operation, registered result with carry and overflow.

// One-bit add/subtract slice; subtraction inverts the B bit, the +1 comes in
// through the carry flop preset at load time.
module serial_add_sub_slice (
    input  logic a,
    input  logic b,
    input  logic m,
    input  logic ci,
    output logic s,
    output logic co
);
    logic bx;

    assign bx = b ^ m;
    assign s  = a ^ bx ^ ci;
    assign co = (a & bx) | (a & ci) | (bx & ci);
endmodule

module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             M,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             m_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             bit_s;
    logic             bit_co;
    logic             last_bit;

    serial_add_sub_slice u_slice (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .m  (m_q),
        .ci (carry),
        .s  (bit_s),
        .co (bit_co)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    // Control FSM, operand/result shifters and the result registers.
    // Operands are captured at start, so input changes during RUN are invisible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            m_q   <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        r_sh  <= '0;
                        m_q   <= M;
                        carry <= M;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    carry <= bit_co;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= {bit_s, r_sh[WIDTH-1:1]};
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // carry still holds carry-in of the MSB here
                        S     <= {bit_s, r_sh[WIDTH-1:1]};
                        Cout  <= bit_co;
                        V     <= carry ^ bit_co;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub (WIDTH=8): directed vectors with
// hand-computed results, checked by an independent monitor on done.
module tb_serial_add_sub;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         M;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
    logic         V;

    exp_t         expq[$];
    int           cmp_cnt = 0;
    int           err_cnt = 0;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .M     (M),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .V     (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops the scoreboard on done, checks busy run length, result
    // hold between operations and busy/done exclusivity.
    exp_t         exp_hold;
    int           busy_run;
    initial begin
        exp_hold = '0;
        busy_run = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_hold = '0;
            busy_run = 0;
        end else begin
            cmp_cnt++;
            if (busy && done) begin
                err_cnt++;
                $display("FAIL busy_done_excl: busy=%0b done=%0b, required not both high", busy, done);
            end
            if (busy) busy_run++;
            if (done) begin
                if (expq.size() == 0) begin
                    cmp_cnt++; err_cnt++;
                    $display("FAIL unexpected_done: done=1 with S=%h, required no done pulse", S);
                end else begin
                    e = expq.pop_front();
                    cmp_cnt += 4;
                    if (S !== e.s) begin
                        err_cnt++;
                        $display("FAIL result_S: got %h, required %h", S, e.s);
                    end
                    if (Cout !== e.c) begin
                        err_cnt++;
                        $display("FAIL result_Cout: got %b, required %b (S=%h)", Cout, e.c, e.s);
                    end
                    if (V !== e.v) begin
                        err_cnt++;
                        $display("FAIL result_V: got %b, required %b (S=%h)", V, e.v, e.s);
                    end
                    if (busy_run != W) begin
                        err_cnt++;
                        $display("FAIL busy_length: got %0d cycles, required %0d", busy_run, W);
                    end
                    exp_hold = e;
                end
                busy_run = 0;
            end else begin
                cmp_cnt++;
                if (S !== exp_hold.s || Cout !== exp_hold.c || V !== exp_hold.v) begin
                    err_cnt++;
                    $display("FAIL result_hold: got S=%h C=%b V=%b, required S=%h C=%b V=%b",
                             S, Cout, V, exp_hold.s, exp_hold.c, exp_hold.v);
                end
            end
        end
    end

    // Drive one request (caller is at a negedge) and queue its expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input logic [W-1:0] es, input logic ec, input logic ev);
        exp_t e;
        e.s = es; e.c = ec; e.v = ev;
        expq.push_back(e);
        start = 1'b1; A = a; B = b; M = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Return at the negedge where done is visible, or flag a timeout.
    task automatic wait_done();
        for (int k = 0; k < 40; k++) begin
            if (done) return;
            @(negedge clk);
        end
        cmp_cnt++; err_cnt++;
        $display("FAIL done_timeout: no done within 40 cycles, required done after %0d", W);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                          input logic [W-1:0] es, input logic ec, input logic ev);
        issue(a, b, m, es, ec, ev);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; M = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        cmp_cnt++;
        if ({busy, done, S, Cout, V} !== '0) begin
            err_cnt++;
            $display("FAIL reset_state: got busy=%b done=%b S=%h C=%b V=%b, required all zero",
                     busy, done, S, Cout, V);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // basic add/sub vectors, hand-computed
        run_op(8'h25, 8'h1A, 1'b0, 8'h3F, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op(8'h3C, 8'h5A, 1'b1, 8'hE2, 1'b0, 1'b0);

        // reset mid-operation: start sampled at E0, rst_n low at E3
        start = 1'b1; A = 8'h11; B = 8'h22; M = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if ({busy, done, S, Cout, V} !== '0) begin
            err_cnt++;
            $display("FAIL abort_reset: got busy=%b done=%b S=%h C=%b V=%b, required all zero",
                     busy, done, S, Cout, V);
        end
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_op(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);

        // start toggling and operand changes during RUN must be ignored
        issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            start = i[0];
            A = 8'hA5 ^ 8'(i);
            B = 8'h5A + 8'(i);
            M = ~i[0];
            @(negedge clk);
        end
        start = 1'b0;
        wait_done();
        @(negedge clk);
        repeat (3) @(negedge clk);

        // back-to-back: new start held during the DONE cycle
        issue(8'h40, 8'h02, 1'b0, 8'h42, 1'b0, 1'b0);
        wait_done();
        issue(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0);
        cmp_cnt++;
        if (!busy) begin
            err_cnt++;
            $display("FAIL b2b_busy: got busy=%b, required 1 right after DONE start", busy);
        end
        wait_done();
        @(negedge clk);

        repeat (5) @(negedge clk);
        cmp_cnt++;
        if (expq.size() != 0) begin
            err_cnt++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
